// File: rtl/data_mem_pl.sv
// Preloadable data memory: zero-fill (CLEAR), streamed preload (LOAD), then byte-lane run-mode access (RUN).
// Optional macro DMEM_RD_FWD_EN forwards a same-cycle run-mode write to the combinational read port.
module data_mem_pl #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 10,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                ld_valid,
   input  logic [DATA_W-1:0]   ld_data,
   output logic                ld_ready,
   input  logic                ld_skip,
   input  logic                we,
   input  logic [DATA_W/8-1:0] wbe,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [DATA_W-1:0]   rdata,
   output logic                addr_err,
   output logic [DEPTH-1:0]    ptr_led,
   output logic                over
);

   localparam int unsigned NB = DATA_W / 8;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DEPTH-1:0]  LED_MSB   = {1'b1, {(DEPTH-1){1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic              over_q, over_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [NB-1:0]     mem_wr_be;

   logic waddr_ok, raddr_ok;

   assign waddr_ok = {1'b0, waddr} < DEPTH_X;
   assign raddr_ok = {1'b0, raddr} < DEPTH_X;

   // The zero-fill walks its own index so the display pointer stays on word 0 until LOAD begins.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      clr_idx_d   = clr_idx_q;
      mem_wr_en   = 1'b0;
      mem_wr_addr = ptr_q;
      mem_wr_data = '0;
      mem_wr_be   = '0;
      case (state_q)
         ST_CLEAR: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = clr_idx_q;
            mem_wr_be   = '1;
            if (clr_idx_q == LAST_ADDR) begin
               state_d   = ST_LOAD;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         ST_LOAD: begin
            if (ld_skip) begin
               state_d = ST_RUN;
            end else if (ld_valid) begin
               mem_wr_en   = 1'b1;
               mem_wr_addr = ptr_q;
               mem_wr_data = ld_data;
               mem_wr_be   = '1;
               if (ptr_q == LAST_ADDR) state_d = ST_RUN;
               else                    ptr_d   = ptr_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (we && waddr_ok) begin
               mem_wr_en   = 1'b1;
               mem_wr_addr = waddr;
               mem_wr_data = wdata;
               mem_wr_be   = wbe;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
      if (clr) mem_wr_en = 1'b0;
      over_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= ST_CLEAR;
         ptr_q     <= '0;
         clr_idx_q <= '0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         clr_idx_q <= clr_idx_d;
         over_q    <= over_d;
      end
   end

   // Storage has no reset; only the CLEAR sweep zeroes it.
   always_ff @(posedge clk) begin
      if (mem_wr_en) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (mem_wr_be[i]) mem_q[mem_wr_addr][8*i +: 8] <= mem_wr_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (state_q != ST_CLEAR && raddr_ok) begin
         rdata = mem_q[raddr];
`ifdef DMEM_RD_FWD_EN
         if (state_q == ST_RUN && we && waddr == raddr) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (wbe[i]) rdata[8*i +: 8] = wdata[8*i +: 8];
            end
         end
`endif
      end
   end

   assign addr_err = !raddr_ok || (state_q == ST_RUN && we && !waddr_ok);
   assign ld_ready = (state_q == ST_LOAD);
   assign ptr_led  = (state_q == ST_RUN) ? '0 : (LED_MSB >> ptr_q);
   assign over     = over_q;

endmodule

// File: tb/tb_data_mem_pl.sv
// Self-checking bench for data_mem_pl: directed phases plus randomized traffic against a behavioural model.
module tb_data_mem_pl;

   localparam int DW  = 16;
   localparam int DEP = 10;
   localparam int AW  = 4;

   logic          clk = 1'b0;
   logic          clr;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          ld_skip;
   logic          we;
   logic [1:0]    wbe;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;
   logic          addr_err;
   logic [DEP-1:0] ptr_led;
   logic          over;

   always #5 clk = ~clk;

   data_mem_pl #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
      .clk(clk), .clr(clr), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_skip(ld_skip), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .addr_err(addr_err), .ptr_led(ptr_led), .over(over)
   );

   typedef enum {M_CLEAR, M_LOAD, M_RUN} mode_t;
   mode_t         mode;
   int            cleared;
   int            ptr;
   logic [DW-1:0] ref_mem [DEP];
   int            n_vec = 0;
   int            n_err = 0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                           input logic [1:0] be);
      logic [DW-1:0] r = old_v;
      for (int b = 0; b < 2; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] exp_rdata();
      logic [DW-1:0] r;
      if (mode == M_CLEAR || int'(raddr) >= DEP) return '0;
      r = ref_mem[raddr];
`ifdef DMEM_RD_FWD_EN
      if (mode == M_RUN && we && waddr == raddr) r = merge(r, wdata, wbe);
`endif
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [DEP-1:0] one = 1;
      logic [DEP-1:0] led;
      led = (mode == M_RUN) ? '0 : (one << (DEP - 1 - ptr));
      chk("ld_ready", 32'(ld_ready), 32'(mode == M_LOAD));
      chk("over", 32'(over), 32'(mode == M_RUN));
      chk("ptr_led", 32'(ptr_led), 32'(led));
      chk("rdata", 32'(rdata), 32'(exp_rdata()));
      chk("addr_err", 32'(addr_err),
          32'(int'(raddr) >= DEP || (mode == M_RUN && we && int'(waddr) >= DEP)));
   endtask

   task automatic model_reset();
      mode = M_CLEAR;
      cleared = 0;
      ptr = 0;
   endtask

   task automatic model_step();
      case (mode)
         M_CLEAR: begin
            ref_mem[cleared] = '0;
            cleared++;
            if (cleared == DEP) begin mode = M_LOAD; ptr = 0; end
         end
         M_LOAD: begin
            if (ld_skip) mode = M_RUN;
            else if (ld_valid) begin
               ref_mem[ptr] = ld_data;
               if (ptr == DEP - 1) mode = M_RUN;
               else ptr++;
            end
         end
         default: if (we && int'(waddr) < DEP) ref_mem[waddr] = merge(ref_mem[waddr], wdata, wbe);
      endcase
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle();
      #1 check_outputs();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_run_inputs();
      we    = 1'($urandom_range(0, 1));
      wbe   = 2'($urandom);
      waddr = 4'($urandom_range(0, 15));
      wdata = 16'($urandom);
      raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
   endtask

   task automatic do_clear();
      clr = 1'b1;
      #1 model_reset();
      @(negedge clk);
      clr = 1'b0;
      repeat (DEP) begin
         rand_run_inputs();
         ld_valid = 1'b0;
         ld_skip  = 1'b0;
         ld_data  = 16'($urandom);
         cycle();
      end
   endtask

   initial begin
      clr = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_skip = 1'b0;
      we = 1'b0; wbe = '0; waddr = '0; wdata = '0; raddr = '0;
      model_reset();
      #2 check_outputs();
      @(negedge clk);
      clr = 1'b0;

      // Zero-fill: ld_ready only on the 11th cycle.
      repeat (DEP) begin
         rand_run_inputs();
         cycle();
      end

      // Full preload, then an extra offer that must be ignored.
      for (int i = 0; i <= DEP; i++) begin
         rand_run_inputs();
         we = 1'b0;
         ld_valid = 1'b1;
         ld_data  = (i < DEP) ? 16'(16'h0100 + i) : 16'hDEAD;
         cycle();
      end
      ld_valid = 1'b0;
      for (int a = 0; a < 16; a++) begin
         we = 1'b0; raddr = 4'(a);
         cycle();
      end

      // Directed run-mode writes and out-of-range accesses.
      we = 1'b1; wbe = 2'b11; waddr = 4'd3; wdata = 16'hABCD; raddr = 4'd0; cycle();
      we = 1'b1; wbe = 2'b01; waddr = 4'd3; wdata = 16'h1234; raddr = 4'd3; cycle();
      we = 1'b0; raddr = 4'd3; cycle();
      we = 1'b1; wbe = 2'b11; waddr = 4'd12; wdata = 16'hFFFF; raddr = 4'd3; cycle();
      we = 1'b0; raddr = 4'd10; cycle();
      we = 1'b1; wbe = 2'b11; waddr = 4'd2; wdata = 16'hAAAA; raddr = 4'd2; cycle();
      we = 1'b1; wbe = 2'b11; waddr = 4'd2; wdata = 16'h5555; raddr = 4'd2; cycle();
      we = 1'b0; raddr = 4'd2; cycle();

      repeat (200) begin
         rand_run_inputs();
         ld_valid = 1'($urandom_range(0, 1));
         ld_skip  = 1'($urandom_range(0, 1));
         cycle();
      end
      ld_valid = 1'b0; ld_skip = 1'b0;

      // Skip after four accepts; a simultaneous offer must not be written.
      do_clear();
      for (int i = 0; i < 4; i++) begin
         we = 1'b0; ld_valid = 1'b1; ld_data = 16'(16'h0200 + i); raddr = 4'(i); cycle();
      end
      ld_valid = 1'b1; ld_skip = 1'b1; ld_data = 16'h7777; raddr = 4'd4; cycle();
      ld_valid = 1'b0; ld_skip = 1'b0;
      for (int a = 0; a < 6; a++) begin
         we = 1'b0; raddr = 4'(a); cycle();
      end

      // Asynchronous clr between edges after six accepts.
      do_clear();
      for (int i = 0; i < 6; i++) begin
         we = 1'b0; ld_valid = 1'b1; ld_data = 16'(16'h0300 + i); raddr = 4'(i); cycle();
      end
      #2 clr = 1'b1;
      #1 model_reset();
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      ld_valid = 1'b0;
      repeat (DEP) begin rand_run_inputs(); cycle(); end
      for (int a = 0; a < 6; a++) begin
         we = 1'b0; raddr = 4'(a); cycle();
      end

      // Randomized preload with gaps and occasional skip, then random run traffic.
      do_clear();
      repeat (40) begin
         rand_run_inputs();
         ld_valid = ($urandom_range(0, 9) < 7);
         ld_skip  = ($urandom_range(0, 19) == 0);
         ld_data  = 16'($urandom);
         cycle();
      end
      ld_valid = 1'b0; ld_skip = 1'b0;
      repeat (150) begin
         rand_run_inputs();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_pl.md
DATA_MEM_PL -- requirements
Module: data_mem_pl

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, word width in bits; must be a multiple of 8.
REQ-002 SHALL provide parameter DEPTH, default 10, number of words.
REQ-003 SHALL provide parameter ADDR_W, default 4, address width, with 2**ADDR_W >= DEPTH.
REQ-004 SHALL provide port clk  input  1  clock; all state changes occur on the rising edge.
REQ-005 SHALL provide port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port ld_valid  input  1  preload word offered.
REQ-007 SHALL provide port ld_data  input  DATA_W  preload word.
REQ-008 SHALL provide port ld_ready  output  1  preload word accepted this cycle when high with ld_valid.
REQ-009 SHALL provide port ld_skip  input  1  abandon preload and enter run mode.
REQ-010 SHALL provide port we  input  1  run-mode write enable.
REQ-011 SHALL provide port wbe  input  DATA_W/8  byte-lane write enables; bit i covers bits 8i+7..8i.
REQ-012 SHALL provide port waddr  input  ADDR_W  run-mode write address.
REQ-013 SHALL provide port wdata  input  DATA_W  run-mode write data.
REQ-014 SHALL provide port raddr  input  ADDR_W  read address.
REQ-015 SHALL provide port rdata  output  DATA_W  read data.
REQ-016 SHALL provide port addr_err  output  1  out-of-range access flag.
REQ-017 SHALL provide port ptr_led  output  DEPTH  one-hot preload pointer display.
REQ-018 SHALL provide port over  output  1  preload complete / run mode active.

Function
REQ-019 SHALL implement the FSM states CLEAR, LOAD and RUN, with RUN terminal until clr.
REQ-020 CLEAR SHALL write zero to mem[ptr] each cycle for ptr = 0..DEPTH-1, then enter LOAD with ptr=0; total DEPTH cycles.
REQ-021 LOAD SHALL hold ld_ready=1; on ld_valid&&ld_ready, SHALL write ld_data to mem[ptr] (all bytes) and increment ptr.
REQ-022 Acceptance at ptr==DEPTH-1 SHALL move to RUN next cycle; ptr SHALL NOT wrap.
REQ-023 ld_skip=1 in LOAD SHALL move to RUN next cycle and SHALL take priority over a same-cycle ld_valid, with no write performed.
REQ-024 ld_ready SHALL be 0 in CLEAR and RUN; ld_valid, ld_data and ld_skip SHALL be ignored outside LOAD.
REQ-025 ptr_led SHALL have only bit DEPTH-1-ptr set in CLEAR and LOAD (MSB = word 0), and SHALL be all-zero in RUN.
REQ-026 over SHALL be 1 exactly in RUN, registered.
REQ-027 In RUN, on we=1 with waddr<DEPTH, the block SHALL update only the byte lanes of mem[waddr] whose wbe bit is 1, at the rising edge.
REQ-028 we/wbe/waddr/wdata SHALL be ignored in CLEAR and LOAD.
REQ-029 A run-mode write with waddr>=DEPTH SHALL be discarded with memory unchanged.
REQ-030 Read SHALL be combinational, zero latency: rdata=mem[raddr] when raddr<DEPTH, else 0; rdata SHALL be 0 in CLEAR.
REQ-031 addr_err SHALL be combinational: 1 when raddr>=DEPTH, or when RUN and we and waddr>=DEPTH; else 0.

Reset
REQ-032 clr=1 SHALL immediately force state=CLEAR, ptr=0, over=0, ptr_led=MSB only and ld_ready=0, regardless of clk.
REQ-033 clr asserted mid-LOAD or mid-CLEAR SHALL discard progress; clearing SHALL restart from word 0 after clr deasserts.
REQ-034 Memory contents SHALL NOT be reset asynchronously; they SHALL be zeroed only by CLEAR.

Configuration
REQ-035 With macro DMEM_RD_FWD_EN defined, in RUN with we=1, waddr==raddr<DEPTH, rdata SHALL return the byte-merged new value (wdata on wbe lanes, stored data elsewhere) in the same cycle.
REQ-036 Without DMEM_RD_FWD_EN, rdata SHALL return the stored (pre-write) contents in that cycle.

Verification
REQ-037 Pulse clr, hold ld_valid=0 -> over=0, ptr_led=10'b1000000000 during 10 CLEAR cycles, ld_ready rises on cycle 11, every raddr reads 0.
REQ-038 LOAD with ld_valid=1 and ld_data=16'h0100+i for 10 accepts -> ptr_led walks MSB to LSB, over=1 after 10th accept, mem[i]=16'h0100+i, an 11th ld_valid ignored.
REQ-039 RUN: write mem[3]=16'hABCD, then we with wbe=2'b01, wdata=16'h1234 -> mem[3]=16'hAB34; waddr=12 with we -> addr_err=1, no memory change; raddr=10 -> rdata=0, addr_err=1.
REQ-040 LOAD after 4 accepts, ld_skip=1 with ld_valid=1 -> no write to mem[4] (reads 0), over=1 next cycle, ptr_led=0.
REQ-041 After 6 accepts, assert clr asynchronously between edges -> over=0, ptr_led=MSB immediately, CLEAR reruns, mem[0..5] read 0 afterwards.
REQ-042 Same-cycle we to mem[2] (16'h5555) with raddr=2 holding 16'hAAAA, wbe=2'b11 -> rdata=16'h5555 with DMEM_RD_FWD_EN, 16'hAAAA without.
